// File: rtl/cobra_pkg.sv
// Shared encodings for the multi-cycle cobra core: ALU opcodes, write-source
// select, instruction field positions and the control FSM state type.
package cobra_pkg;

  // ALU opcodes; the 2'b11 prefix marks compare ops that drive the branch flag
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

  // register write source
  localparam logic [1:0] WS_NONE = 2'b00;
  localparam logic [1:0] WS_IN   = 2'b01;
  localparam logic [1:0] WS_IMM  = 2'b10;
  localparam logic [1:0] WS_ALU  = 2'b11;

  // instruction field bit positions
  localparam int F_J      = 31;
  localparam int F_B      = 30;
  localparam int F_WS_HI  = 29;
  localparam int F_WS_LO  = 28;
  localparam int F_OP_HI  = 27;
  localparam int F_OP_LO  = 23;
  localparam int F_RA1_HI = 22;
  localparam int F_RA1_LO = 18;
  localparam int F_RA2_HI = 17;
  localparam int F_RA2_LO = 13;
  localparam int F_OFF_HI = 12;
  localparam int F_OFF_LO = 5;
  localparam int F_WA_HI  = 4;
  localparam int F_WA_LO  = 0;
  localparam int F_IMM_HI = 27;
  localparam int F_IMM_LO = 5;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

endpackage

// File: rtl/cobra_alu.sv
// Combinational ALU: arithmetic/logic result plus compare flag used for branches.
// Compare ops also return the flag as a 0/1 result so B+WS=11 can store it.
module cobra_alu
  import cobra_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            flag_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lts;
  logic           ltu;
  logic           eq;

  assign shamt = b_i[SHW-1:0];
  assign lts   = $signed(a_i) < $signed(b_i);
  assign ltu   = a_i < b_i;
  assign eq    = a_i == b_i;

  // opcode decode into result and flag
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLTS: result_o = {{(XLEN-1){1'b0}}, lts};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, ltu};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_EQ:   flag_o   = eq;
      ALU_NE:   flag_o   = !eq;
      ALU_LTS:  flag_o   = lts;
      ALU_GES:  flag_o   = !lts;
      ALU_LTU:  flag_o   = ltu;
      ALU_GEU:  flag_o   = !ltu;
      default:  result_o = '0;
    endcase
    if (op_i[4:3] == 2'b11) result_o = {{(XLEN-1){1'b0}}, flag_o};
  end

endmodule

// File: rtl/cobra_core_mc.sv
// Multi-cycle cobra core: two cycles per instruction (fetch, execute), stalls
// on the input handshake, strobes OUT results, stops for good on jump-to-self.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_FETCH   | imem_addr = PC presented; ROM word arrives next cycle
//   ST_EXEC    | decode ROM word, read regs, commit write + PC, or divert
//   ST_WAIT_IN | input instruction waiting for in_valid; PC held
//   ST_HALT    | jump-to-self reached; frozen until reset
module cobra_core_mc
  import cobra_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 10,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_valid,
  output logic            halted
);
  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic            rf_we;
  logic            rf_wr_en;

  logic [31:0]       instr;
  logic              f_j;
  logic              f_b;
  logic [1:0]        f_ws;
  logic [4:0]        f_op;
  logic [7:0]        f_off;
  logic [XLEN-1:0]   f_imm;
  logic [RIDX_W-1:0] ra1_idx, ra2_idx, wa_idx;
  logic [XLEN-1:0]   rd1, rd2, wr_data;
  logic [XLEN-1:0]   alu_res;
  logic              alu_flag;
  logic              is_out, is_halt, taken;
  logic [PC_W-1:0]   pc_next;

  // register addresses wrap modulo the implemented register count
  function automatic logic [RIDX_W-1:0] reg_idx(input logic [4:0] a);
    return RIDX_W'(int'(a) % NREG);
  endfunction

  // while stalled the ROM word is replayed from the copy latched in EXEC
  assign instr   = (state_q == ST_WAIT_IN) ? instr_q : imem_rdata;
  assign f_j     = instr[F_J];
  assign f_b     = instr[F_B];
  assign f_ws    = instr[F_WS_HI:F_WS_LO];
  assign f_op    = instr[F_OP_HI:F_OP_LO];
  assign f_off   = instr[F_OFF_HI:F_OFF_LO];
  assign f_imm   = {{(XLEN-23){instr[F_IMM_HI]}}, instr[F_IMM_HI:F_IMM_LO]};
  assign ra1_idx = reg_idx(instr[F_RA1_HI:F_RA1_LO]);
  assign ra2_idx = reg_idx(instr[F_RA2_HI:F_RA2_LO]);
  assign wa_idx  = reg_idx(instr[F_WA_HI:F_WA_LO]);

  assign rd1 = (ra1_idx == '0) ? '0 : rf_q[ra1_idx];
  assign rd2 = (ra2_idx == '0) ? '0 : rf_q[ra2_idx];

  cobra_alu #(.XLEN(XLEN)) u_alu (
    .op_i     (f_op),
    .a_i      (rd1),
    .b_i      (rd2),
    .result_o (alu_res),
    .flag_o   (alu_flag)
  );

  assign is_out  = !f_j && !f_b && (f_ws == WS_NONE) && instr[F_OP_HI];
  assign is_halt = f_j && (f_off == 8'd0);
  assign taken   = f_j || (f_b && alu_flag);
  assign pc_next = pc_q + (taken ? PC_W'({{22{f_off[7]}}, f_off, 2'b00}) : PC_W'(4));

  // write-back source select
  always_comb begin
    wr_data = '0;
    case (f_ws)
      WS_IN:   wr_data = in_data;
      WS_IMM:  wr_data = f_imm;
      WS_ALU:  wr_data = alu_res;
      default: wr_data = '0;
    endcase
  end

  // next-state, PC, write enable and handshake decode
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    rf_we       = 1'b0;
    in_ready    = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        instr_d  = imem_rdata;
        in_ready = (f_ws == WS_IN);
        if ((f_ws == WS_IN) && !in_valid) begin
          state_d = ST_WAIT_IN;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          rf_we   = (f_ws != WS_NONE);
          pc_d    = pc_next;
          state_d = ST_FETCH;
          if (is_out) begin
            out_data_d  = rd1;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rf_we   = 1'b1;
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // x0 is hardwired to zero, so its writes are dropped here
  assign rf_wr_en = rf_we && (wa_idx != '0);

  // control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // register file: single write port at the end of the committing cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_wr_en) begin
      rf_q[wa_idx] <= wr_data;
    end
  end

  assign imem_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cobra_core_mc.sv
// Scoreboarded bench for cobra_core_mc: directed scenarios plus random programs
// whose OUT stream, halt address and input consumption come from an ISA model.
module tb_cobra_core_mc;
  localparam int XLEN  = 32;
  localparam int PC_W  = 10;
  localparam int NREG  = 32;
  localparam int ROM_W = 256;
  localparam logic [4:0] OPS [16] = '{5'b00000, 5'b01000, 5'b00001, 5'b00010,
                                      5'b00011, 5'b00100, 5'b00101, 5'b01101,
                                      5'b00110, 5'b00111, 5'b11000, 5'b11001,
                                      5'b11100, 5'b11101, 5'b11110, 5'b11111};
  localparam logic [31:0] HALT_W = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic [XLEN-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] out_data;
  logic            out_valid;
  logic            halted;

  cobra_core_mc #(.XLEN(XLEN), .PC_W(PC_W), .NREG(NREG)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  logic [31:0]     rom [ROM_W];
  logic [XLEN-1:0] inputs [512];
  logic [XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] mq [$];
  int n_tests = 0, n_fail = 0;
  int drv_mode = 2, stall_n = 0, ready_cnt = 0, in_idx = 0, out_pulses = 0;
  int m_halt_pc, m_nin;
  logic prev_ov = 1'b0;

  // synchronous instruction ROM, one cycle latency
  always @(posedge clk) imem_rdata <= rom[imem_addr[PC_W-1:2]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // input driver: random, stall-then-valid, or never valid
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && in_ready) ready_cnt++;
      case (drv_mode)
        0:       in_valid = ($urandom_range(0, 1) == 1);
        1:       in_valid = (ready_cnt > stall_n);
        default: in_valid = 1'b0;
      endcase
      in_data = inputs[in_idx % 512];
      #4;
      if (reset_n && in_valid && in_ready) in_idx++;
    end
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      out_pulses++;
      check("out_strobe_single", {63'b0, prev_ov}, 64'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h, expected no output", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
    prev_ov = out_valid;
  end

  function automatic logic [31:0] mk(input logic j, input logic b, input logic [1:0] ws,
                                     input logic [4:0] op, input logic [4:0] ra1,
                                     input logic [4:0] ra2, input logic [7:0] off,
                                     input logic [4:0] wa);
    return {j, b, ws, op, ra1, ra2, off, wa};
  endfunction

  function automatic logic [31:0] konst(input int v, input logic [4:0] wa);
    logic [31:0] t;
    t = v;
    return {4'b0010, t[22:0], wa};
  endfunction

  function automatic logic [31:0] out_i(input logic [4:0] ra1);
    return mk(1'b0, 1'b0, 2'b00, 5'b10000, ra1, 5'd0, 8'd0, 5'd0);
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < ROM_W; i++) rom[i] = HALT_W;
  endtask

  function automatic void m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic f);
    r = '0;
    f = 1'b0;
    case (op)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << b[4:0];
      5'b00010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: r = (a < b) ? 32'd1 : 32'd0;
      5'b00100: r = a ^ b;
      5'b00101: r = a >> b[4:0];
      5'b01101: r = $signed(a) >>> b[4:0];
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b11000: f = (a == b);
      5'b11001: f = (a != b);
      5'b11100: f = ($signed(a) < $signed(b));
      5'b11101: f = ($signed(a) >= $signed(b));
      5'b11110: f = (a < b);
      5'b11111: f = (a >= b);
      default:  r = '0;
    endcase
    if (op[4:3] == 2'b11) r = {31'b0, f};
  endfunction

  // ISA-level interpreter: expected OUT values, halt address, inputs consumed
  function automatic bit model_run();
    logic [31:0] x [32];
    logic [31:0] w, rd1, rd2, res, val;
    logic signed [7:0] o8;
    logic f;
    int pc, nin, off;
    pc = 0;
    nin = 0;
    mq.delete();
    for (int i = 0; i < 32; i++) x[i] = '0;
    for (int s = 0; s < 300; s++) begin
      w   = rom[pc / 4];
      rd1 = x[w[22:18]];
      rd2 = x[w[17:13]];
      if (w[31] && w[12:5] == 8'd0) begin
        m_halt_pc = pc;
        m_nin = nin;
        return 1'b1;
      end
      m_alu(w[27:23], rd1, rd2, res, f);
      case (w[29:28])
        2'b01: begin val = inputs[nin]; nin++; end
        2'b10: val = {{9{w[27]}}, w[27:5]};
        2'b11: val = res;
        default: val = '0;
      endcase
      if (w[29:28] != 2'b00 && w[4:0] != 5'd0) x[w[4:0]] = val;
      if (w[31:28] == 4'b0000 && w[27]) mq.push_back(rd1);
      o8 = w[12:5];
      off = o8;
      if (w[31] || (w[30] && f)) pc = (pc + 4 * off) & 1023;
      else pc = (pc + 4) & 1023;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] op, ra1, ra2, wa;
    logic [1:0] ws;
    int k, o;
    op  = OPS[$urandom_range(0, 15)];
    ra1 = 5'($urandom_range(0, 7));
    ra2 = 5'($urandom_range(0, 7));
    wa  = 5'($urandom_range(0, 7));
    o   = int'($urandom_range(0, 10)) - 4;
    k   = int'($urandom_range(0, 9));
    case (k)
      0, 1: return konst(int'($urandom), wa);
      2, 3: return mk(1'b0, 1'b0, 2'b11, op, ra1, ra2, 8'(o), wa);
      4:    return mk(1'b0, 1'b0, 2'b01, op, ra1, ra2, 8'(o), wa);
      5:    return {5'b00001, 27'($urandom)};
      6:    return mk(1'b0, 1'b1, 2'b00, op, ra1, ra2, 8'(o), wa);
      7: begin
        if (o == 0) o = 2;
        ws = 2'($urandom_range(0, 2));
        if (ws == 2'b01) ws = 2'b11;
        return mk(1'b1, 1'b0, ws, op, ra1, ra2, 8'(o), wa);
      end
      8:    return mk(1'b0, 1'b0, 2'b00, {1'b0, op[3:0]}, ra1, ra2, 8'(o), wa);
      default: return mk(1'b0, 1'b1, 2'b11, op, ra1, ra2, 8'(o), wa);
    endcase
  endfunction

  task automatic start();
    reset_n = 1'b0;
    exp_q.delete();
    in_idx = 0;
    ready_cnt = 0;
    out_pulses = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget, input string nm);
    int c;
    c = 0;
    while (!halted && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_halted"}, {63'b0, halted}, 64'd1);
    @(negedge clk);
    check({nm, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit ok;
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    fill_halt();
    for (int i = 0; i < 512; i++) inputs[i] = $urandom;

    // T1: reset state and fetch sequence
    rom[0] = konst(5, 5'd1);
    rom[1] = out_i(5'd1);
    rom[2] = HALT_W;
    drv_mode = 2;
    reset_n = 1'b0;
    #12;
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_halted", {63'b0, halted}, 64'd0);
    start();
    exp_q.push_back(32'd5);
    check("t1_addr_c0", 64'(imem_addr), 64'd0);
    @(negedge clk);
    check("t1_addr_c1", 64'(imem_addr), 64'd0);
    @(negedge clk);
    check("t1_addr_c2", 64'(imem_addr), 64'd4);
    wait_halt(100, "t1");

    // T2: ALU add then OUT
    fill_halt();
    rom[0] = konst(5, 5'd1);
    rom[1] = konst(7, 5'd2);
    rom[2] = mk(1'b0, 1'b0, 2'b11, 5'b00000, 5'd1, 5'd2, 8'd0, 5'd3);
    rom[3] = out_i(5'd3);
    start();
    exp_q.push_back(32'd12);
    wait_halt(100, "t2");
    check("t2_out_pulses", 64'(out_pulses), 64'd1);

    // T3: input stall, five cycles without valid
    fill_halt();
    rom[0] = mk(1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 8'd0, 5'd4);
    rom[1] = out_i(5'd4);
    inputs[0] = 32'hA5;
    drv_mode = 1;
    stall_n = 5;
    start();
    exp_q.push_back(32'hA5);
    wait_halt(100, "t3");
    check("t3_ready_cycles", 64'(ready_cnt), 64'd6);
    check("t3_inputs_used", 64'(in_idx), 64'd1);
    check("t3_halt_pc", 64'(imem_addr), 64'd8);

    // T4: signed branch taken backwards / not taken
    for (int v = 0; v < 2; v++) begin
      fill_halt();
      rom[0] = konst((v == 0) ? 3 : 9, 5'd1);
      rom[1] = konst(9, 5'd2);
      rom[2] = mk(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 8'd3, 5'd0);
      rom[3] = out_i(5'd1);
      rom[4] = HALT_W;
      rom[5] = mk(1'b0, 1'b1, 2'b00, 5'b11100, 5'd1, 5'd2, 8'hFE, 5'd0);
      rom[6] = out_i(5'd2);
      rom[7] = HALT_W;
      drv_mode = 2;
      start();
      exp_q.push_back((v == 0) ? 32'd3 : 32'd9);
      wait_halt(100, "t4");
      check("t4_halt_pc", 64'(imem_addr), (v == 0) ? 64'd16 : 64'd28);
    end

    // T5: x0 stays zero; halt freezes fetch address
    fill_halt();
    rom[0] = konst(77, 5'd0);
    rom[1] = out_i(5'd0);
    start();
    exp_q.push_back(32'd0);
    wait_halt(100, "t5");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t5_addr_frozen", 64'(imem_addr), 64'd8);
    end
    check("t5_still_halted", {63'b0, halted}, 64'd1);

    // T6: async reset while waiting for input
    fill_halt();
    rom[0] = mk(1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 8'd0, 5'd4);
    rom[1] = out_i(5'd4);
    inputs[0] = 32'hEE;
    drv_mode = 2;
    start();
    repeat (6) @(negedge clk);
    check("t6_waiting_ready", {63'b0, in_ready}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_addr", 64'(imem_addr), 64'd0);
    check("t6_rst_in_ready", {63'b0, in_ready}, 64'd0);
    fill_halt();
    rom[0] = out_i(5'd4);
    drv_mode = 1;
    stall_n = 0;
    start();
    exp_q.push_back(32'd0);
    wait_halt(100, "t6");
    check("t6_halt_pc", 64'(imem_addr), 64'd4);

    // random programs against the ISA model
    for (int p = 0; p < 6; p++) begin
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        fill_halt();
        for (int i = 0; i < 512; i++) inputs[i] = $urandom;
        for (int i = 0; i < 40; i++) rom[i] = rand_instr();
        ok = model_run();
      end
      if (!ok) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_gen: got no terminating program, expected one");
      end else begin
        drv_mode = 0;
        start();
        foreach (mq[i]) exp_q.push_back(mq[i]);
        wait_halt(4000, "rand");
        check("rand_halt_pc", 64'(imem_addr), 64'(m_halt_pc));
        check("rand_inputs_used", 64'(in_idx), 64'(m_nin));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
